// File: rtl/mem_arb.sv
// mem_arb: shares one fixed-latency single-port memory between the fetch and data ports.
// Optional build macro ARB_STARVE_GUARD_EN enables a starvation guard that periodically forces a fetch grant.
module mem_arb #(
    parameter int LAT    = 2,
    parameter int STARVE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_done,
    output logic [15:0] if_rdata,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_done,
    output logic [15:0] dm_rdata,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    // Handshake: a port raises req and holds it (with addr/data) until its done pulse;
    // the port's values are latched at grant, so later changes have no effect on that access.

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

    localparam logic [2:0] LAT_M1 = 3'(LAT - 1);

    state_t      state, state_nx;
    logic [2:0]  cnt;
    logic        owner_dm;
    logic        lat_wr;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic        grant_dm, grant_if, fetch_pri;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [2:0] STARVE_C = 3'(STARVE);
    logic [2:0] starve_cnt;

    assign fetch_pri = if_req && (starve_cnt >= STARVE_C);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 3'd0;
        end else if (grant_if) begin
            starve_cnt <= 3'd0;
        end else if (grant_dm) begin
            if (!if_req)
                starve_cnt <= 3'd0;
            else if (starve_cnt < STARVE_C)
                starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    assign fetch_pri = 1'b0;
`endif

    assign grant_dm = (state == IDLE) && dm_req && !fetch_pri;
    assign grant_if = (state == IDLE) && if_req && !grant_dm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_dm || grant_if) state_nx = ACC;
            ACC:     if (cnt == 3'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 3'd0;
            owner_dm  <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= 16'h0;
            lat_wdata <= 16'h0;
            if_rdata  <= 16'h0;
            dm_rdata  <= 16'h0;
        end else if (grant_dm || grant_if) begin
            owner_dm  <= grant_dm;
            lat_addr  <= grant_dm ? dm_addr : if_addr;
            lat_wr    <= grant_dm && dm_wr;   // fetch never writes
            lat_wdata <= grant_dm ? dm_wdata : 16'h0;
            cnt       <= LAT_M1;
        end else if (state == ACC) begin
            if (cnt == 3'd0) begin
                if (!lat_wr) begin
                    if (owner_dm) dm_rdata <= mem_rdata;
                    else          if_rdata <= mem_rdata;
                end
            end else begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    // Memory bus is zeroed whenever not enabled; reset clears it combinationally via state.
    assign mem_en    = (state == ACC);
    assign mem_wr    = mem_en && lat_wr;
    assign mem_addr  = mem_en ? lat_addr  : 16'h0;
    assign mem_wdata = mem_en ? lat_wdata : 16'h0;

    assign if_done  = (state == DONE) && !owner_dm;
    assign dm_done  = (state == DONE) && owner_dm;
    assign if_stall = if_req && !if_done;
    assign dm_stall = dm_req && !dm_done;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// Directed testbench for mem_arb (LAT=2, STARVE=3); expectations are hand-computed per cycle.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_wr;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_done, dm_done, if_stall, dm_stall, mem_en, mem_wr, busy;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arb #(.LAT(2), .STARVE(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic exp_dm [5];

    initial begin
        // Reset with random inputs: everything observable must be zero.
        rst       = 1'b0;
        if_req    = 1'($urandom_range(0, 1));
        if_addr   = 16'($urandom_range(0, 65535));
        dm_req    = 1'($urandom_range(0, 1));
        dm_wr     = 1'($urandom_range(0, 1));
        dm_addr   = 16'($urandom_range(0, 65535));
        dm_wdata  = 16'($urandom_range(0, 65535));
        mem_rdata = 16'($urandom_range(0, 65535));
        tick();
        tick();
        check("rst_mem_en", 16'(mem_en), 16'h0);
        check("rst_mem_wr", 16'(mem_wr), 16'h0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        check("rst_if_done", 16'(if_done), 16'h0);
        check("rst_dm_done", 16'(dm_done), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_if_rdata", if_rdata, 16'h0);
        check("rst_dm_rdata", dm_rdata, 16'h0);
        check("rst_if_stall", 16'(if_stall), 16'(if_req));
        if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
        if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 16'h0; mem_rdata = 16'h0;
        tick();
        rst = 1'b1;
        tick();
        check("idle_busy", 16'(busy), 16'h0);
        check("idle_mem_en", 16'(mem_en), 16'h0);

        // Single fetch: cycle 0 request, mem_en cycles 1-2, done at 3.
        if_req = 1'b1; if_addr = 16'h0010;
        #1 check("f_stall_c0", 16'(if_stall), 16'h1);
        tick();
        check("f_mem_en_c1", 16'(mem_en), 16'h1);
        check("f_mem_addr_c1", mem_addr, 16'h0010);
        check("f_mem_wr_c1", 16'(mem_wr), 16'h0);
        check("f_stall_c1", 16'(if_stall), 16'h1);
        mem_rdata = 16'hBEEF;
        tick();
        check("f_mem_en_c2", 16'(mem_en), 16'h1);
        check("f_mem_addr_c2", mem_addr, 16'h0010);
        check("f_done_c2", 16'(if_done), 16'h0);
        check("f_stall_c2", 16'(if_stall), 16'h1);
        tick();
        check("f_done_c3", 16'(if_done), 16'h1);
        check("f_rdata_c3", if_rdata, 16'hBEEF);
        check("f_mem_en_c3", 16'(mem_en), 16'h0);
        check("f_mem_addr_c3", mem_addr, 16'h0);
        check("f_stall_c3", 16'(if_stall), 16'h0);
        check("f_dm_done_c3", 16'(dm_done), 16'h0);
        if_req = 1'b0;
        tick();
        check("f_done_c4", 16'(if_done), 16'h0);
        check("f_busy_c4", 16'(busy), 16'h0);
        check("f_rdata_hold", if_rdata, 16'hBEEF);

        // Simultaneous: data write wins, fetch follows at cycle 5.
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0040; dm_wdata = 16'h1234;
        if_req = 1'b1; if_addr = 16'h0002; mem_rdata = 16'h5555;
        tick();
        check("s_mem_wr_c1", 16'(mem_wr), 16'h1);
        check("s_mem_wdata_c1", mem_wdata, 16'h1234);
        check("s_mem_addr_c1", mem_addr, 16'h0040);
        check("s_if_stall_c1", 16'(if_stall), 16'h1);
        tick();
        check("s_mem_wr_c2", 16'(mem_wr), 16'h1);
        check("s_mem_wdata_c2", mem_wdata, 16'h1234);
        tick();
        check("s_dm_done_c3", 16'(dm_done), 16'h1);
        check("s_if_done_c3", 16'(if_done), 16'h0);
        check("s_dm_stall_c3", 16'(dm_stall), 16'h0);
        check("s_mem_wr_c3", 16'(mem_wr), 16'h0);
        check("s_mem_wdata_c3", mem_wdata, 16'h0);
        check("s_dm_rdata_c3", dm_rdata, 16'h0);
        dm_req = 1'b0; dm_wr = 1'b0;
        tick();
        check("s_mem_en_c4", 16'(mem_en), 16'h0);
        tick();
        check("s_mem_en_c5", 16'(mem_en), 16'h1);
        check("s_mem_addr_c5", mem_addr, 16'h0002);
        check("s_mem_wr_c5", 16'(mem_wr), 16'h0);
        check("s_mem_wdata_c5", mem_wdata, 16'h0);
        tick();
        check("s_mem_en_c6", 16'(mem_en), 16'h1);
        tick();
        check("s_if_done_c7", 16'(if_done), 16'h1);
        check("s_if_rdata_c7", if_rdata, 16'h5555);
        check("s_dm_rdata_c7", dm_rdata, 16'h0);
        if_req = 1'b0;
        tick();

        // Both ports held for five accesses: grant order visible from done pulses.
`ifdef ARB_STARVE_GUARD_EN
        exp_dm = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0080;
        if_req = 1'b1; if_addr = 16'h0004; mem_rdata = 16'h7777;
        for (int k = 0; k < 5; k++) begin
            tick();
            tick();
            tick();
            check($sformatf("st_dm_done_%0d", k), 16'(dm_done), 16'(exp_dm[k]));
            check($sformatf("st_if_done_%0d", k), 16'(if_done), 16'(!exp_dm[k]));
            if (k == 4) begin
                dm_req = 1'b0; if_req = 1'b0;
            end
            tick();
        end
        check("st_dm_rdata", dm_rdata, 16'h7777);
        check("st_busy_end", 16'(busy), 16'h0);

        // Data read dropped mid-access still completes with latched address.
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0100; mem_rdata = 16'hA5A5;
        tick();
        dm_req = 1'b0; dm_addr = 16'h0999;
        #1;
        check("d_mem_en_c1", 16'(mem_en), 16'h1);
        check("d_mem_addr_c1", mem_addr, 16'h0100);
        check("d_dm_stall_c1", 16'(dm_stall), 16'h0);
        tick();
        check("d_mem_en_c2", 16'(mem_en), 16'h1);
        check("d_mem_addr_c2", mem_addr, 16'h0100);
        tick();
        check("d_dm_done_c3", 16'(dm_done), 16'h1);
        check("d_dm_rdata_c3", dm_rdata, 16'hA5A5);
        tick();

        // Reset in cycle 1 of a fetch: drops it immediately, then a fresh fetch runs.
        if_req = 1'b1; if_addr = 16'h0020; mem_rdata = 16'h3C3C;
        tick();
        check("r_mem_en_c1", 16'(mem_en), 16'h1);
        #2 rst = 1'b0;
        #1;
        check("r_mem_en_async", 16'(mem_en), 16'h0);
        check("r_mem_addr_async", mem_addr, 16'h0);
        check("r_busy_async", 16'(busy), 16'h0);
        check("r_if_rdata_async", if_rdata, 16'h0);
        check("r_dm_rdata_async", dm_rdata, 16'h0);
        tick();
        check("r_if_done_hold1", 16'(if_done), 16'h0);
        tick();
        check("r_if_done_hold2", 16'(if_done), 16'h0);
        rst = 1'b1;
        tick();
        check("r2_mem_en_c1", 16'(mem_en), 16'h1);
        check("r2_mem_addr_c1", mem_addr, 16'h0020);
        tick();
        check("r2_done_c2", 16'(if_done), 16'h0);
        tick();
        check("r2_done_c3", 16'(if_done), 16'h1);
        check("r2_rdata_c3", if_rdata, 16'h3C3C);
        if_req = 1'b0;
        tick();
        check("r2_busy_c4", 16'(busy), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
